// File: rtl/accel_sequencer.sv
// accel_sequencer
// Owns the shared SPI register-access engine for the accelerometer path.
// After reset it writes a fixed configuration list (soft reset, settle wait,
// filter, power) and then runs a four-register read burst (X, Y, Z, STATUS)
// on each sample tick. The four results are published together, with one
// valid pulse, so the display/register stage always sees a coherent set.
//
// Ports
//   ck          system clock, all state on the rising edge
//   reset       asynchronous active-low reset
//   tick        one-cycle sample request
//   spi_start   transaction request level to the SPI engine
//   spi_rw      1 = write, 0 = read
//   spi_addr    register address
//   spi_wdata   write data (0 on reads)
//   spi_ready   one-cycle end-of-transaction pulse from the engine
//   spi_rdata   read byte, valid in the spi_ready cycle
//   x_data..status  last committed sample set
//   valid       one-cycle pulse when a new set is committed
//   init_done   high once configuration has completed
//   busy        high in any state other than IDLE
//   err         sticky transaction-timeout flag
module accel_sequencer #(
    parameter logic [26:0] SETTLE_CYCLES  = 27'd5_000_000,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4_000
) (
    input  logic       ck,
    input  logic       reset,
    input  logic       tick,
    output logic       spi_start,
    output logic       spi_rw,
    output logic [7:0] spi_addr,
    output logic [7:0] spi_wdata,
    input  logic       spi_ready,
    input  logic [7:0] spi_rdata,
    output logic [7:0] x_data,
    output logic [7:0] y_data,
    output logic [7:0] z_data,
    output logic [7:0] status,
    output logic       valid,
    output logic       init_done,
    output logic       busy,
    output logic       err
);

    typedef enum logic [3:0] {
        W_SRST, WAIT_SETTLE, W_FILT, W_PWR, IDLE,
        R_X, R_Y, R_Z, R_S, GAP, COMMIT
    } state_e;

    state_e      state_q, state_d;
    state_e      ret_q, ret_d;
    logic [26:0] settleCnt_q, settleCnt_d;
    logic [15:0] tmoCnt_q, tmoCnt_d;
    logic        pend_q, pend_d;
    logic [7:0]  shX_q, shX_d, shY_q, shY_d, shZ_q, shZ_d, shS_q, shS_d;
    logic        start_q, start_d, rw_q, rw_d;
    logic [7:0]  addr_q, addr_d, wdata_q, wdata_d;
    logic [7:0]  x_q, x_d, y_q, y_d, z_q, z_d, s_q, s_d;
    logic        valid_q, valid_d, initDone_q, initDone_d;
    logic        busy_q, busy_d, err_q, err_d;
    logic        readyOk, timeoutHit;

    // Ready only counts while a request is actually on the wire, so stray
    // pulses in GAP/IDLE/WAIT_SETTLE have no effect.
    assign readyOk    = start_q & spi_ready;
    assign timeoutHit = start_q & ~spi_ready & (tmoCnt_q == TIMEOUT_CYCLES - 16'd1);

    // Next-state logic followed by the registered outputs, which are all
    // derived from the upcoming state so they change together with it.
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        settleCnt_d = settleCnt_q;
        pend_d      = pend_q;
        shX_d       = shX_q;
        shY_d       = shY_q;
        shZ_d       = shZ_q;
        shS_d       = shS_q;

        // One-deep tick memory while the burst engine is occupied.
        if (tick && initDone_q && state_q != IDLE) begin
            pend_d = 1'b1;
        end

        case (state_q)
            W_SRST: begin
                if (readyOk) begin
                    state_d = GAP;
                    ret_d   = WAIT_SETTLE;
                end else if (timeoutHit) begin
                    state_d = GAP;
                    ret_d   = W_SRST;
                end
            end
            WAIT_SETTLE: begin
                if (settleCnt_q == SETTLE_CYCLES - 27'd1) begin
                    settleCnt_d = 27'd0;
                    state_d     = W_FILT;
                end else begin
                    settleCnt_d = settleCnt_q + 27'd1;
                end
            end
            W_FILT: begin
                if (readyOk) begin
                    state_d = GAP;
                    ret_d   = W_PWR;
                end else if (timeoutHit) begin
                    state_d = GAP;
                    ret_d   = W_SRST;
                end
            end
            W_PWR: begin
                if (readyOk) begin
                    state_d = GAP;
                    ret_d   = IDLE;
                end else if (timeoutHit) begin
                    state_d = GAP;
                    ret_d   = W_SRST;
                end
            end
            IDLE: begin
                if (tick || pend_q) begin
                    state_d = R_X;
                    pend_d  = 1'b0;
                end
            end
            R_X: begin
                if (readyOk) begin
                    shX_d   = spi_rdata;
                    state_d = GAP;
                    ret_d   = R_Y;
                end else if (timeoutHit) begin
                    state_d = IDLE;
                end
            end
            R_Y: begin
                if (readyOk) begin
                    shY_d   = spi_rdata;
                    state_d = GAP;
                    ret_d   = R_Z;
                end else if (timeoutHit) begin
                    state_d = IDLE;
                end
            end
            R_Z: begin
                if (readyOk) begin
                    shZ_d   = spi_rdata;
                    state_d = GAP;
                    ret_d   = R_S;
                end else if (timeoutHit) begin
                    state_d = IDLE;
                end
            end
            R_S: begin
                if (readyOk) begin
                    shS_d   = spi_rdata;
                    state_d = GAP;
                    ret_d   = COMMIT;
                end else if (timeoutHit) begin
                    state_d = IDLE;
                end
            end
            GAP:     state_d = ret_q;
            COMMIT:  state_d = IDLE;
            default: state_d = W_SRST;
        endcase

        start_d = 1'b0;
        rw_d    = 1'b0;
        addr_d  = 8'h00;
        wdata_d = 8'h00;
        case (state_d)
            W_SRST: begin start_d = 1'b1; rw_d = 1'b1; addr_d = 8'h1F; wdata_d = 8'h52; end
            W_FILT: begin start_d = 1'b1; rw_d = 1'b1; addr_d = 8'h2C; wdata_d = 8'h13; end
            W_PWR:  begin start_d = 1'b1; rw_d = 1'b1; addr_d = 8'h2D; wdata_d = 8'h02; end
            R_X:    begin start_d = 1'b1; addr_d = 8'h08; end
            R_Y:    begin start_d = 1'b1; addr_d = 8'h09; end
            R_Z:    begin start_d = 1'b1; addr_d = 8'h0A; end
            R_S:    begin start_d = 1'b1; addr_d = 8'h0B; end
            default: ;
        endcase

        // Counts request cycles; any completion, timeout or GAP restarts it.
        tmoCnt_d = (start_q && !spi_ready && !timeoutHit) ? tmoCnt_q + 16'd1 : 16'd0;

        // IDLE is only reachable through a clean configuration pass.
        initDone_d = initDone_q | (state_d == IDLE);
        busy_d     = (state_d != IDLE);
        err_d      = err_q | timeoutHit;
        valid_d    = (state_d == COMMIT);
        x_d        = (state_d == COMMIT) ? shX_q : x_q;
        y_d        = (state_d == COMMIT) ? shY_q : y_q;
        z_d        = (state_d == COMMIT) ? shZ_q : z_q;
        s_d        = (state_d == COMMIT) ? shS_q : s_q;
    end

    // State and output registers; reset drops every output asynchronously.
    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            state_q     <= W_SRST;
            ret_q       <= W_SRST;
            settleCnt_q <= 27'd0;
            tmoCnt_q    <= 16'd0;
            pend_q      <= 1'b0;
            shX_q       <= 8'h00;
            shY_q       <= 8'h00;
            shZ_q       <= 8'h00;
            shS_q       <= 8'h00;
            start_q     <= 1'b0;
            rw_q        <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            x_q         <= 8'h00;
            y_q         <= 8'h00;
            z_q         <= 8'h00;
            s_q         <= 8'h00;
            valid_q     <= 1'b0;
            initDone_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            settleCnt_q <= settleCnt_d;
            tmoCnt_q    <= tmoCnt_d;
            pend_q      <= pend_d;
            shX_q       <= shX_d;
            shY_q       <= shY_d;
            shZ_q       <= shZ_d;
            shS_q       <= shS_d;
            start_q     <= start_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            s_q         <= s_d;
            valid_q     <= valid_d;
            initDone_q  <= initDone_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign spi_start = start_q;
    assign spi_rw    = rw_q;
    assign spi_addr  = addr_q;
    assign spi_wdata = wdata_q;
    assign x_data    = x_q;
    assign y_data    = y_q;
    assign z_data    = z_q;
    assign status    = s_q;
    assign valid     = valid_q;
    assign init_done = initDone_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_accel_sequencer.sv
// Directed bench for accel_sequencer with a small SPI engine responder.
module tb_accel_sequencer;

    localparam logic [26:0] SETTLE = 27'd10;
    localparam logic [15:0] TMO    = 16'd50;

    logic       ck = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       spi_ready = 1'b0;
    logic [7:0] spi_rdata = 8'h00;
    logic       spi_start, spi_rw, valid, init_done, busy, err;
    logic [7:0] spi_addr, spi_wdata, x_data, y_data, z_data, status;

    accel_sequencer #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .ck       (ck),
        .reset    (reset),
        .tick     (tick),
        .spi_start(spi_start),
        .spi_rw   (spi_rw),
        .spi_addr (spi_addr),
        .spi_wdata(spi_wdata),
        .spi_ready(spi_ready),
        .spi_rdata(spi_rdata),
        .x_data   (x_data),
        .y_data   (y_data),
        .z_data   (z_data),
        .status   (status),
        .valid    (valid),
        .init_done(init_done),
        .busy     (busy),
        .err      (err)
    );

    always #5 ck = ~ck;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge ck) cyc <= cyc + 1;

    // Engine responder: answers a request after engDelay cycles unless the
    // address is being withheld.
    int          engDelay = 20;
    int          engCnt = 0;
    bit          holdEn = 1'b0;
    logic [7:0]  holdAddr = 8'h00;
    logic [7:0]  rdMem [4];
    logic [16:0] txLog [$];
    int          readyQ [$];

    always @(negedge ck) begin
        spi_ready = 1'b0;
        if (!reset) begin
            engCnt = 0;
        end else if (spi_start && !(holdEn && spi_addr == holdAddr)) begin
            engCnt++;
            if (engCnt >= engDelay) begin
                spi_ready = 1'b1;
                spi_rdata = spi_rw ? 8'h00 : rdMem[spi_addr[1:0]];
                txLog.push_back({spi_rw, spi_addr, spi_wdata});
                readyQ.push_back(cyc);
                engCnt = 0;
            end
        end else begin
            engCnt = 0;
        end
    end

    // Output monitor sampled on the falling edge.
    bit          prevStart = 1'b0;
    bit          prevValid = 1'b0;
    logic [31:0] prevData = 32'h0;
    int          fallCount = 0;
    int          validCount = 0;
    int          validLong = 0;
    int          dataGlitch = 0;
    int          initCyc = -1;
    int          riseQ [$];

    always @(negedge ck) begin
        if (prevStart && !spi_start) fallCount++;
        if (!prevStart && spi_start) riseQ.push_back(cyc);
        prevStart = spi_start;
        if (valid) validCount++;
        if (valid && prevValid) validLong++;
        prevValid = valid;
        if ({x_data, y_data, z_data, status} != prevData && !valid && reset) dataGlitch++;
        prevData = {x_data, y_data, z_data, status};
        if (init_done && initCyc < 0) initCyc = cyc;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge ck);
            #1;
        end
    endtask

    task automatic applyStimulus();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int earlyBad;
        int commitCyc;
        int hiCnt;
        logic errLast;

        rdMem = '{8'h12, 8'h34, 8'h56, 8'h80};

        // Reset state
        step(3);
        checkOutput("rst_ctrl", {26'd0, spi_start, spi_rw, valid, init_done, busy, err}, 32'd0);
        checkOutput("rst_addr", {16'd0, spi_addr, spi_wdata}, 32'd0);
        checkOutput("rst_data", {x_data, y_data, z_data, status}, 32'd0);

        // Configuration pass
        reset = 1'b1;
        earlyBad = 0;
        for (int i = 0; i < 400 && !init_done; i++) begin
            step(1);
            if (!init_done && (valid || {x_data, y_data, z_data, status} != 32'd0)) earlyBad++;
        end
        checkOutput("init_done_reached", {31'd0, init_done}, 32'd1);
        checkOutput("init_early_outputs", earlyBad, 0);
        checkOutput("init_log_len", txLog.size(), 3);
        checkOutput("init_wr0", {15'd0, txLog[0]}, {15'd0, 1'b1, 8'h1F, 8'h52});
        checkOutput("init_wr1", {15'd0, txLog[1]}, {15'd0, 1'b1, 8'h2C, 8'h13});
        checkOutput("init_wr2", {15'd0, txLog[2]}, {15'd0, 1'b1, 8'h2D, 8'h02});
        checkOutput("init_done_latency", initCyc - readyQ[2], 2);
        checkOutput("settle_duration", riseQ[1] - readyQ[0], 12);
        checkOutput("init_busy_idle", {31'd0, busy}, 32'd0);

        // Single burst
        step(2);
        fallCount = 0;
        validCount = 0;
        applyStimulus();
        checkOutput("burst_start", {23'd0, spi_start, spi_rw, spi_addr}, {23'd0, 1'b1, 1'b0, 8'h08});
        checkOutput("burst_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 300 && !valid; i++) step(1);
        checkOutput("burst1_valid", {31'd0, valid}, 32'd1);
        checkOutput("burst1_data", {x_data, y_data, z_data, status}, 32'h12345680);
        step(1);
        checkOutput("burst1_valid_width", {31'd0, valid}, 32'd0);
        checkOutput("burst1_gaps", fallCount, 4);
        checkOutput("burst1_valid_count", validCount, 1);

        // Three ticks during one burst
        rdMem = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        step(3);
        validCount = 0;
        applyStimulus();
        step(5);
        applyStimulus();
        step(2);
        applyStimulus();
        step(2);
        applyStimulus();
        for (int i = 0; i < 300 && !valid; i++) step(1);
        commitCyc = cyc;
        checkOutput("burst2_data", {x_data, y_data, z_data, status}, 32'hA1B2C3D4);
        step(1);
        for (int i = 0; i < 10 && !spi_start; i++) step(1);
        checkOutput("pend_restart_latency", cyc - commitCyc, 2);
        checkOutput("pend_restart_addr", {24'd0, spi_addr}, 32'h08);
        for (int i = 0; i < 300 && !valid; i++) step(1);
        checkOutput("burst3_valid", {31'd0, valid}, 32'd1);
        step(150);
        checkOutput("pend_valid_count", validCount, 2);
        checkOutput("valid_single_cycle", validLong, 0);

        // Read timeout on R_Y
        rdMem = '{8'h11, 8'h22, 8'h33, 8'h44};
        holdEn = 1'b1;
        holdAddr = 8'h09;
        validCount = 0;
        applyStimulus();
        for (int i = 0; i < 100 && !(spi_start && spi_addr == 8'h09); i++) step(1);
        checkOutput("tmo_ry_reached", {24'd0, spi_addr}, 32'h09);
        hiCnt = 0;
        errLast = 1'b1;
        for (int i = 0; i < 200 && spi_start; i++) begin
            hiCnt++;
            errLast = err;
            step(1);
        end
        checkOutput("tmo_cycles", hiCnt, 50);
        checkOutput("tmo_err_before", {31'd0, errLast}, 32'd0);
        checkOutput("tmo_err_set", {31'd0, err}, 32'd1);
        checkOutput("tmo_idle", {31'd0, busy}, 32'd0);
        step(5);
        checkOutput("tmo_no_valid", validCount, 0);
        checkOutput("tmo_data_held", {x_data, y_data, z_data, status}, 32'hA1B2C3D4);

        holdEn = 1'b0;
        applyStimulus();
        for (int i = 0; i < 300 && !valid; i++) step(1);
        checkOutput("tmo_recover_data", {x_data, y_data, z_data, status}, 32'h11223344);
        checkOutput("tmo_err_sticky", {31'd0, err}, 32'd1);

        // Reset pulsed during R_Z
        step(3);
        applyStimulus();
        for (int i = 0; i < 300 && !(spi_start && spi_addr == 8'h0A); i++) step(1);
        step(3);
        checkOutput("rz_reached", {23'd0, spi_start, spi_addr}, {23'd0, 1'b1, 8'h0A});
        reset = 1'b0;
        #1;
        checkOutput("arst_ctrl", {27'd0, spi_start, busy, valid, init_done, err}, 32'd0);
        checkOutput("arst_data", {x_data, y_data, z_data, status}, 32'd0);
        checkOutput("arst_addr", {16'd0, spi_addr, spi_wdata}, 32'd0);

        // Init restart with W_PWR withheld
        holdEn = 1'b1;
        holdAddr = 8'h2D;
        step(2);
        reset = 1'b1;
        for (int i = 0; i < 20 && !spi_start; i++) step(1);
        checkOutput("restart_srst", {15'd0, spi_rw, spi_addr, spi_wdata}, {15'd0, 1'b1, 8'h1F, 8'h52});
        for (int i = 0; i < 400 && !(spi_start && spi_addr == 8'h2D); i++) step(1);
        checkOutput("pwr_reached", {24'd0, spi_addr}, 32'h2D);
        for (int i = 0; i < 200 && spi_start; i++) step(1);
        checkOutput("pwr_tmo_err", {31'd0, err}, 32'd1);
        checkOutput("pwr_tmo_no_init", {31'd0, init_done}, 32'd0);
        for (int i = 0; i < 20 && !spi_start; i++) step(1);
        checkOutput("pwr_tmo_reissue", {23'd0, spi_rw, spi_addr}, {23'd0, 1'b1, 8'h1F});
        holdEn = 1'b0;
        for (int i = 0; i < 400 && !init_done; i++) step(1);
        checkOutput("pwr_clean_init", {31'd0, init_done}, 32'd1);
        checkOutput("pwr_err_sticky", {31'd0, err}, 32'd1);
        checkOutput("data_only_on_commit", dataGlitch, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/accel_sequencer.md
# accel_sequencer

Sequencer that owns the shared SPI register-access engine of the accelerometer path. After reset it configures the sensor with a fixed write list and waits for it to settle. It then runs a 4-register read burst (X, Y, Z, STATUS) on every sample tick. Results go out as a coherent, simultaneously updated set for the display/register stage.

## Interface
Parameters:
- SETTLE_CYCLES, 27'd5_000_000, wait after soft reset (50 ms at 100 MHz)
- TIMEOUT_CYCLES, 16'd4_000, max cycles `spi_start` may stay high without `spi_ready`

Ports:
- ck  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- tick  in  1  one-cycle sample request
- spi_start  out  1  transaction request level to the SPI engine
- spi_rw  out  1  1 = write (cmd 0x0A), 0 = read (cmd 0x0B)
- spi_addr  out  8  register address
- spi_wdata  out  8  write data (0 on reads)
- spi_ready  in  1  one-cycle pulse from the engine at end of transaction
- spi_rdata  in  8  read byte, valid in the `spi_ready` cycle
- x_data, y_data, z_data, status  out  8 each  last committed sample set
- valid  out  1  one-cycle pulse when a new set is committed
- init_done  out  1  high once configuration has completed
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky timeout flag

## Operation
- Reset value of every output is 0, including data registers, `spi_addr` and `spi_wdata`. After reset release the FSM starts in W_SRST.
- Transaction states drive `spi_start`=1 with fixed rw/addr/wdata and hold it until `spi_ready`=1 is sampled.
- Every transaction state is followed by one GAP cycle with `spi_start`=0, so the engine returns to idle before the next request.
- Init sequence:
  - W_SRST: write 0x1F=0x52.
  - WAIT_SETTLE: counts SETTLE_CYCLES.
  - W_FILT: write 0x2C=0x13.
  - W_PWR: write 0x2D=0x02.
  - Then `init_done`=1 and the FSM enters IDLE.
- IDLE: on `tick` or a set pending flag, clear pending and go to R_X.
- Read burst:
  - R_X reads 0x08, R_Y reads 0x09, R_Z reads 0x0A, R_S reads 0x0B.
  - Each read captures `spi_rdata` into a shadow register in its `spi_ready` cycle.
- COMMIT: copies all four shadows into the outputs at once, pulses `valid`, then returns to IDLE.
- Tick while busy:
  - Sets a one-deep pending flag. Further ticks are dropped.
  - A tick in the same cycle the FSM leaves IDLE is consumed, not pended.
  - Ticks before `init_done` are ignored and do not pend.
- Timeout:
  - A 16-bit counter runs while `spi_start`=1 and clears at each GAP.
  - When it reaches TIMEOUT_CYCLES, `err` is set (sticky until reset).
  - In init, the FSM restarts at W_SRST.
  - In a read burst, the FSM abandons the set: no commit, no `valid`, outputs unchanged, back to IDLE. Pending is kept.
- `spi_ready` seen outside a transaction state is ignored.

## Timing
- Request to engine: `spi_start` rises in the first cycle of a transaction state, registered from the state.
- Completion: the cycle after `spi_ready`=1 is GAP (`spi_start`=0). The following cycle is the next transaction state or COMMIT.
- Burst latency: from the tick cycle, R_X is entered on the next edge. `valid` is high exactly one cycle, the cycle after the GAP following R_S's ready.
- `x_data`..`status` change only on the COMMIT edge and are stable otherwise.
- A pending tick re-enters R_X two cycles after COMMIT (COMMIT→IDLE→R_X).
- Asserting reset low mid-transaction drops `spi_start` asynchronously. All outputs return to 0 and `err` clears.
- WAIT_SETTLE lasts exactly SETTLE_CYCLES cycles (counter 0..SETTLE_CYCLES-1).

## Test plan
- Reset release with SETTLE_CYCLES=10 and an engine model giving ready 20 cycles after start -> writes 1F/52, 2C/13, 2D/02 in order. `init_done` rises after the third ready plus GAP. All outputs 0 before that.
- Tick after init, engine returns 0x12, 0x34, 0x56, 0x80 -> x=0x12, y=0x34, z=0x56, status=0x80 all update on the same edge. `valid` is a single-cycle pulse, 4 GAP cycles with `spi_start`=0 are observed.
- Three ticks during one burst -> exactly one extra burst follows, R_X entered 2 cycles after the first COMMIT, and 2 `valid` pulses in total.
- Engine withholds ready on R_Y with TIMEOUT_CYCLES=50 -> `err`=1 after 50 cycles, no `valid`, previous data held, and the next tick runs a full burst normally.
- Engine withholds ready on W_PWR -> `err`=1 and the sequence restarts at W_SRST (addr 0x1F reissued). `init_done` stays 0 until a clean pass.
- Reset pulsed low during R_Z -> `spi_start`, `busy`, data, `err` and `init_done` all 0 asynchronously. After release the init sequence restarts from W_SRST.
